// File: rtl/ldm_writeback_sequencer_pkg.sv
// Shared definitions for the LDM writeback sequencer: state encoding, stride and
// register-number constants, and the reglist scan result type.
package ldm_writeback_sequencer_pkg;

  localparam int LDM_ADDR_W     = 32;
  localparam int LDM_WORD_BYTES = 4;

  localparam logic [3:0] REG_PC = 4'd15;
  localparam logic [3:0] REG_LR = 4'd14;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_REQ    = 3'd1;
  localparam logic [2:0] ST_WRITE  = 3'd2;
  localparam logic [2:0] ST_BASEWB = 3'd3;
  localparam logic [2:0] ST_FIN    = 3'd4;

  typedef struct packed {
    logic       any;
    logic [3:0] idx;
    logic [4:0] cnt;
  } scan_t;

endpackage

// File: rtl/ldm_writeback_sequencer_if.sv
// Control, memory-read and register-file-write signals of the LDM sequencer.
// PC_LOAD/PC_DATA exist only when LDM_PC_LOAD_EN is defined.
interface ldm_writeback_sequencer_if #(
  parameter int ADDR_W = 32
);

  logic              start;
  logic [15:0]       reglist;
  logic [ADDR_W-1:0] base;
  logic [3:0]        basereg;
  logic              up;
  logic              wback;

  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [ADDR_W-1:0] mem_rdata;
  logic              mem_valid;

  logic              we3;
  logic [3:0]        wa3;
  logic [ADDR_W-1:0] wd3;
  logic              busy;
  logic              done;

`ifdef LDM_PC_LOAD_EN
  logic              pc_load;
  logic [ADDR_W-1:0] pc_data;
`endif

  modport master (
    input  start, reglist, base, basereg, up, wback, mem_rdata, mem_valid,
    output mem_re, mem_addr, we3, wa3, wd3, busy, done
`ifdef LDM_PC_LOAD_EN
    , output pc_load, pc_data
`endif
  );

  modport slave (
    output start, reglist, base, basereg, up, wback, mem_rdata, mem_valid,
    input  mem_re, mem_addr, we3, wa3, wd3, busy, done
`ifdef LDM_PC_LOAD_EN
    , input pc_load, pc_data
`endif
  );

endinterface

// File: rtl/ldm_writeback_sequencer_reglist_scan.sv
// Combinational lowest-set-bit index and popcount over a 16-bit register list.
module ldm_writeback_sequencer_reglist_scan
  import ldm_writeback_sequencer_pkg::*;
(
  input  logic [15:0] list_i,
  output scan_t       scan_o
);

  logic       any;
  logic [3:0] idx;
  logic [4:0] cnt;

  // Scanning downward lets the last hit (the lowest set bit) win.
  always_comb begin
    any = 1'b0;
    idx = 4'd0;
    cnt = 5'd0;
    for (int i = 15; i >= 0; i--) begin
      if (list_i[i]) begin
        any = 1'b1;
        idx = 4'(i);
      end
    end
    for (int i = 0; i < 16; i++) begin
      cnt = cnt + 5'(list_i[i]);
    end
  end

  assign scan_o = '{any: any, idx: idx, cnt: cnt};

endmodule

// File: rtl/ldm_writeback_sequencer.sv
// Multi-cycle LDM engine driving the register-file write port (WE3/WA3/WD3).
// Optional macro LDM_PC_LOAD_EN redirects R15 loads to PC_LOAD/PC_DATA.
module ldm_writeback_sequencer
  import ldm_writeback_sequencer_pkg::*;
#(
  parameter int ADDR_W     = LDM_ADDR_W,
  parameter int WORD_BYTES = LDM_WORD_BYTES
) (
  input  logic                       clk,
  input  logic                       rst,
  ldm_writeback_sequencer_if.master  bus
);

  logic [2:0]        state_q, state_d;
  logic [15:0]       list_q, list_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] final_q, final_d;
  logic [ADDR_W-1:0] data_q, data_d;
  logic [3:0]        basereg_q, basereg_d;
  logic              wb_q, wb_d;

  logic [15:0]       scan_list;
  scan_t             scan;
  logic [ADDR_W-1:0] span;
  logic [15:0]       remaining;
  logic              wb_start;

  // In IDLE the scanner looks at the incoming list so START can size the transfer.
  assign scan_list = (state_q == ST_IDLE) ? bus.reglist : list_q;

  ldm_writeback_sequencer_reglist_scan u_scan (
    .list_i (scan_list),
    .scan_o (scan)
  );

  assign span      = ADDR_W'(scan.cnt) * ADDR_W'(WORD_BYTES);
  assign remaining = list_q & ~(16'd1 << scan.idx);
  assign wb_start  = bus.wback & ~bus.reglist[bus.basereg];

  always_comb begin
    state_d   = state_q;
    list_d    = list_q;
    addr_d    = addr_q;
    final_d   = final_q;
    data_d    = data_q;
    basereg_d = basereg_q;
    wb_d      = wb_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          list_d    = bus.reglist;
          basereg_d = bus.basereg;
          wb_d      = wb_start;
          addr_d    = bus.up ? bus.base : bus.base - span;
          final_d   = bus.up ? bus.base + span : bus.base - span;
          if (scan.any)     state_d = ST_REQ;
          else if (wb_start) state_d = ST_BASEWB;
          else              state_d = ST_FIN;
        end
      end
      ST_REQ: begin
        if (bus.mem_valid) begin
          data_d  = bus.mem_rdata;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        list_d = remaining;
        addr_d = addr_q + ADDR_W'(WORD_BYTES);
        if (remaining != 16'd0) state_d = ST_REQ;
        else if (wb_q)          state_d = ST_BASEWB;
        else                    state_d = ST_FIN;
      end
      ST_BASEWB: state_d = ST_FIN;
      ST_FIN:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      list_q    <= '0;
      addr_q    <= '0;
      final_q   <= '0;
      data_q    <= '0;
      basereg_q <= '0;
      wb_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      list_q    <= list_d;
      addr_q    <= addr_d;
      final_q   <= final_d;
      data_q    <= data_d;
      basereg_q <= basereg_d;
      wb_q      <= wb_d;
    end
  end

  logic              we3;
  logic [3:0]        wa3;
  logic [ADDR_W-1:0] wd3;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_data;

  // The register-file port is decoded purely from registered state.
  always_comb begin
    we3     = 1'b0;
    wa3     = 4'd0;
    wd3     = '0;
    pc_load = 1'b0;
    pc_data = '0;
    case (state_q)
      ST_WRITE: begin
        wa3 = scan.idx;
        wd3 = data_q;
`ifdef LDM_PC_LOAD_EN
        if (scan.idx == REG_PC) begin
          pc_load = 1'b1;
          pc_data = {data_q[ADDR_W-1:2], 2'b00};
        end else begin
          we3 = 1'b1;
        end
`else
        we3 = 1'b1;
`endif
      end
      ST_BASEWB: begin
        we3 = 1'b1;
        wa3 = basereg_q;
        wd3 = final_q;
      end
      default: ;
    endcase
  end

  assign bus.mem_re   = (state_q == ST_REQ);
  assign bus.mem_addr = addr_q;
  assign bus.we3      = we3;
  assign bus.wa3      = wa3;
  assign bus.wd3      = wd3;
  assign bus.busy     = (state_q == ST_REQ) || (state_q == ST_WRITE) ||
                        (state_q == ST_BASEWB);
  assign bus.done     = (state_q == ST_FIN);

`ifdef LDM_PC_LOAD_EN
  assign bus.pc_load  = pc_load;
  assign bus.pc_data  = pc_data;
`else
  logic unused_pc;
  assign unused_pc = pc_load ^ (^pc_data);
`endif

endmodule

// File: tb/tb_ldm_writeback_sequencer.sv
// Scoreboard bench for ldm_writeback_sequencer: expected reads and register writes
// are queued from a reference model when an LDM is launched and popped as the DUT acts.
module tb_ldm_writeback_sequencer;
  import ldm_writeback_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ldm_writeback_sequencer_if #(.ADDR_W(32)) bus ();

  ldm_writeback_sequencer #(.ADDR_W(32), .WORD_BYTES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0]  wa;
    logic [31:0] wd;
    logic        pc;
  } wr_t;

  wr_t         wrQ[$];
  logic [31:0] addrQ[$];
  int          checks = 0;
  int          errors = 0;
  int          memDelay = 0;
  int          waitCnt = 0;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // Memory responder: answers a held read after memDelay cycles of waiting.
  always @(negedge clk) begin
    if (bus.mem_re === 1'b1) begin
      if (waitCnt >= memDelay) begin
        bus.mem_valid = 1'b1;
        bus.mem_rdata = memWord(bus.mem_addr);
      end else begin
        bus.mem_valid = 1'b0;
        bus.mem_rdata = 32'hDEAD_BEEF;
        waitCnt++;
      end
    end else begin
      bus.mem_valid = 1'b0;
      bus.mem_rdata = 32'hDEAD_BEEF;
      waitCnt = 0;
    end
  end

  task automatic expect_op(input logic [15:0] rl, input logic [31:0] base,
                           input logic [3:0] br, input logic up, input logic wb);
    int          cnt;
    logic [31:0] a;
    logic [31:0] fin;
    wr_t         w;
    cnt = 0;
    for (int i = 0; i < 16; i++) cnt += int'(rl[i]);
    a   = up ? base : base - 32'(4 * cnt);
    fin = up ? base + 32'(4 * cnt) : base - 32'(4 * cnt);
    for (int i = 0; i < 16; i++) begin
      if (rl[i]) begin
        addrQ.push_back(a);
        w.wa = 4'(i);
        w.wd = memWord(a);
        w.pc = 1'b0;
`ifdef LDM_PC_LOAD_EN
        if (i == 15) begin
          w.pc = 1'b1;
          w.wd = w.wd & 32'hFFFF_FFFC;
        end
`endif
        wrQ.push_back(w);
        a = a + 32'd4;
      end
    end
    if (wb && !rl[br]) begin
      w.wa = br;
      w.wd = fin;
      w.pc = 1'b0;
      wrQ.push_back(w);
    end
  endtask

  task automatic run_op(input logic [15:0] rl, input logic [31:0] base,
                        input logic [3:0] br, input logic up, input logic wb,
                        input int delay, output int doneCyc, output int reCycles);
    logic        prevRe;
    logic        bad;
    logic [31:0] expAddr;
    wr_t         w;
    memDelay = delay;
    expect_op(rl, base, br, up, wb);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.reglist = rl;
    bus.base    = base;
    bus.basereg = br;
    bus.up      = up;
    bus.wback   = wb;
    @(negedge clk);
    bus.start   = 1'b0;
    bus.reglist = $urandom_range(0, 65535);
    doneCyc  = -1;
    reCycles = 0;
    prevRe   = 1'b0;
    for (int cyc = 1; cyc <= 200 && doneCyc < 0; cyc++) begin
      if (cyc > 1) @(negedge clk);
      checks++;
      if (bus.busy !== ~bus.done) begin
        errors++;
        $display("[TB] FAIL busy_vs_done: cycle %0d busy=%b done=%b", cyc, bus.busy, bus.done);
      end
      if (bus.mem_re === 1'b1 && !prevRe) begin
        checks++;
        if (addrQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_read: addr=%h, no read required", bus.mem_addr);
        end else begin
          expAddr = addrQ.pop_front();
          if (bus.mem_addr !== expAddr) begin
            errors++;
            $display("[TB] FAIL mem_addr: got %h, required %h", bus.mem_addr, expAddr);
          end
        end
      end
      if (bus.mem_re === 1'b1) reCycles++;
      prevRe = (bus.mem_re === 1'b1);
`ifdef LDM_PC_LOAD_EN
      if (bus.we3 === 1'b1 || bus.pc_load === 1'b1) begin
`else
      if (bus.we3 === 1'b1) begin
`endif
        checks++;
        if (wrQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_write: wa3=%0d wd3=%h, no write required", bus.wa3, bus.wd3);
        end else begin
          w = wrQ.pop_front();
          bad = 1'b0;
`ifdef LDM_PC_LOAD_EN
          if (w.pc) bad = (bus.pc_load !== 1'b1) || (bus.we3 !== 1'b0) || (bus.pc_data !== w.wd);
          else      bad = (bus.pc_load !== 1'b0) || (bus.we3 !== 1'b1) ||
                          (bus.wa3 !== w.wa) || (bus.wd3 !== w.wd);
`else
          bad = (bus.we3 !== 1'b1) || (bus.wa3 !== w.wa) || (bus.wd3 !== w.wd);
`endif
          if (bad) begin
            errors++;
            $display("[TB] FAIL reg_write: got we3=%b wa3=%0d wd3=%h, required R%0d=%h pc=%b",
                     bus.we3, bus.wa3, bus.wd3, w.wa, w.wd, w.pc);
          end
        end
      end
      if (bus.done === 1'b1) doneCyc = cyc;
    end
    if (doneCyc < 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_timeout: no DONE within 200 cycles, required DONE");
    end
    checks++;
    if (wrQ.size() != 0 || addrQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL leftover: %0d writes and %0d reads outstanding, required 0",
               wrQ.size(), addrQ.size());
    end
    wrQ.delete();
    addrQ.delete();
  endtask

  task automatic test_reset();
    bus.start   = 1'b0;
    bus.reglist = '0;
    bus.base    = '0;
    bus.basereg = '0;
    bus.up      = 1'b0;
    bus.wback   = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.mem_re, bus.we3, bus.busy, bus.done} !== 4'b0 ||
        bus.mem_addr !== 32'd0 || bus.wa3 !== 4'd0 || bus.wd3 !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: re=%b we3=%b busy=%b done=%b addr=%h wa3=%0d wd3=%h, required all 0",
               bus.mem_re, bus.we3, bus.busy, bus.done, bus.mem_addr, bus.wa3, bus.wd3);
    end
    rst = 1'b0;
  endtask

  task automatic test_increment_wb();
    int d, r;
    run_op(16'h0006, 32'h100, 4'd0, 1'b1, 1'b1, 0, d, r);
    checks++;
    if (d !== 6) begin errors++; $display("[TB] FAIL inc_wb_done_cycle: got %0d, required 6", d); end
  endtask

  task automatic test_decrement_r15();
    int d, r;
    run_op(16'h8001, 32'h200, 4'd2, 1'b0, 1'b0, 0, d, r);
    checks++;
    if (d !== 5) begin errors++; $display("[TB] FAIL dec_done_cycle: got %0d, required 5", d); end
  endtask

  task automatic test_wait_states();
    int d, r;
    run_op(16'h0010, 32'h300, 4'd4, 1'b1, 1'b1, 3, d, r);
    checks++;
    if (r !== 4) begin errors++; $display("[TB] FAIL wait_mem_re_cycles: got %0d, required 4", r); end
    checks++;
    if (d !== 6) begin errors++; $display("[TB] FAIL wait_done_cycle: got %0d, required 6", d); end
  endtask

  task automatic test_empty_list();
    int d, r;
    run_op(16'h0000, 32'h40, 4'd3, 1'b1, 1'b1, 0, d, r);
    checks++;
    if (r !== 0) begin errors++; $display("[TB] FAIL empty_mem_re_cycles: got %0d, required 0", r); end
    checks++;
    if (d !== 2) begin errors++; $display("[TB] FAIL empty_done_cycle: got %0d, required 2", d); end
  endtask

  task automatic test_addr_wrap();
    int d, r;
    run_op(16'h0003, 32'hFFFF_FFFC, 4'd5, 1'b1, 1'b1, 0, d, r);
    checks++;
    if (d !== 6) begin errors++; $display("[TB] FAIL wrap_done_cycle: got %0d, required 6", d); end
  endtask

  task automatic test_reset_mid_op();
    int d, r;
    memDelay = 10;
    @(negedge clk);
    bus.start = 1'b1; bus.reglist = 16'h0003; bus.base = 32'h500;
    bus.basereg = 4'd7; bus.up = 1'b1; bus.wback = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.mem_re !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset_req: mem_re=%b, required 1", bus.mem_re); end
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.mem_re, bus.we3, bus.busy, bus.done} !== 4'b0 || bus.mem_addr !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_abort: re=%b we3=%b busy=%b done=%b addr=%h, required all 0",
               bus.mem_re, bus.we3, bus.busy, bus.done, bus.mem_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (bus.we3 !== 1'b0 || bus.busy !== 1'b0 || bus.mem_re !== 1'b0) begin
        errors++;
        $display("[TB] FAIL post_reset_idle: we3=%b busy=%b re=%b, required 0", bus.we3, bus.busy, bus.mem_re);
      end
    end
    run_op(16'h0021, 32'h800, 4'd1, 1'b1, 1'b1, 0, d, r);
    checks++;
    if (d !== 6) begin errors++; $display("[TB] FAIL after_reset_done_cycle: got %0d, required 6", d); end
  endtask

  task automatic test_back_to_back();
    int          d, r, cnt, dly, expDone;
    logic [15:0] rl;
    logic [31:0] base;
    logic [3:0]  br;
    logic        up, wb;
    for (int k = 0; k < 6; k++) begin
      rl   = 16'($urandom_range(0, 65535));
      base = {$urandom_range(0, 65535), 16'($urandom_range(0, 65535))} & 32'hFFFF_FFFC;
      br   = 4'($urandom_range(0, 15));
      up   = 1'($urandom_range(0, 1));
      wb   = 1'($urandom_range(0, 1));
      dly  = $urandom_range(0, 2);
      cnt  = 0;
      for (int i = 0; i < 16; i++) cnt += int'(rl[i]);
      expDone = cnt * (2 + dly) + 1 + ((wb && !rl[br]) ? 1 : 0);
      run_op(rl, base, br, up, wb, dly, d, r);
      checks++;
      if (d !== expDone) begin
        errors++;
        $display("[TB] FAIL b2b_done_cycle: op %0d got %0d, required %0d", k, d, expDone);
      end
    end
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: time limit reached before completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_increment_wb();
    test_decrement_r15();
    test_wait_states();
    test_empty_list();
    test_addr_wrap();
    test_reset_mid_op();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ldm_writeback_sequencer.md
Name: ldm_writeback_sequencer

Overview:
Multi-cycle load-multiple (LDM) engine that drives the register file write port (WE3/WA3/WD3).
- Walks a 16-bit register list, issues one memory read per set bit, and writes each returned word to the register file.
- Optionally writes the updated base address back to the base register.
- Sits between the decode/execute control and the register file; the pipeline stalls on BUSY.

Parameters:
- ADDR_W, 32, memory address and data width.
- WORD_BYTES, 4, address stride per transferred register.

Ports:
- CLK  in  1  system clock; all state updates on posedge.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  one-cycle pulse; accepted only in IDLE.
- REGLIST  in  16  bit n set means load Rn; sampled on an accepted START.
- BASE  in  32  base address; sampled on START.
- BASEREG  in  4  base register number; sampled on START.
- UP  in  1  1 = increment-after, 0 = decrement-before; sampled on START.
- WBACK  in  1  write updated base to BASEREG; sampled on START.
- MEM_RE  out  1  read request, held until MEM_VALID.
- MEM_ADDR  out  32  read address.
- MEM_RDATA  in  32  read data.
- MEM_VALID  in  1  read data valid; consumed only while MEM_RE=1.
- WE3  out  1  register file write enable.
- WA3  out  4  register file write address.
- WD3  out  32  register file write data.
- BUSY  out  1  high from the cycle after START until DONE.
- DONE  out  1  one-cycle completion pulse.

Behaviour:
- Reset values: state=IDLE; MEM_RE, WE3, BUSY and DONE are 0; MEM_ADDR, WA3 and WD3 are 0. Reset mid-operation aborts immediately with no further writes.
- Notation: CNT = popcount(REGLIST).
- Start address:
  - UP=1: BASE.
  - UP=0: BASE - WORD_BYTES*CNT.
  - Registers are always loaded lowest number first at ascending addresses.
- Final base:
  - UP=1: BASE + WORD_BYTES*CNT.
  - UP=0: BASE - WORD_BYTES*CNT.
- All address arithmetic is mod 2^32; wrap is silent.
- States:
  - IDLE: on START go to REQ with BUSY=1.
  - REQ: assert MEM_RE with MEM_ADDR = current address. On MEM_VALID go to WRITE. The response may arrive in the same cycle as the request, or any number of cycles later.
  - WRITE: one cycle with WE3=1, WA3 = lowest remaining register, WD3 = captured data. Clear that bit and advance the address. Then go to REQ if bits remain; otherwise go to BASEWB if base writeback is required, else to FIN.
  - BASEWB: one cycle with WE3=1, WA3=BASEREG, WD3 = final base.
  - FIN: DONE=1 and BUSY=0 for one cycle, then IDLE.
- Timing: minimum latency with zero-wait memory is 2*CNT+1 cycles from START to DONE (plus 1 with base writeback).
- Base writeback is required when WBACK=1 and REGLIST[BASEREG]=0. If BASEREG is in the list, the loaded value wins and BASEWB is skipped.
- Empty REGLIST: IDLE→BASEWB (if WBACK) → FIN. The final base equals BASE and no memory access occurs.
- START while BUSY is ignored. MEM_VALID outside REQ is ignored.
- WE3 is never high for two consecutive cycles except WRITE followed by BASEWB.

Optional Feature:
Macro: LDM_PC_LOAD_EN.
- Defined:
  - Adds ports PC_LOAD (out, 1) and PC_DATA (out, 32).
  - Loading R15 asserts PC_LOAD for one cycle in its WRITE slot, with PC_DATA = word & ~32'h3, and WE3 stays 0.
  - Required because the register file rewrites R15 every cycle.
- Not defined: R15 is treated as an ordinary register write (WE3=1, WA3=15).

Decomposition:
- Shared package: state encoding (IDLE, REQ, WRITE, BASEWB, FIN), WORD_BYTES, and the R15/R14 register number constants.
- One natural sub-module, reglist_scan: combinational lowest-set-bit index plus popcount over 16 bits. It is instantiated once; the sequencer holds all state.

Test Plan:
1. REGLIST=16'h0006, BASE=32'h100, UP=1, WBACK=1, BASEREG=0, zero-wait memory → R1 ← mem[0x100], R2 ← mem[0x104], R0 ← 0x108; DONE on cycle 6 after START.
2. REGLIST=16'h8001, BASE=32'h200, UP=0, WBACK=0 → reads at 0x1F8 (R0) and 0x1FC (R15); with LDM_PC_LOAD_EN, PC_LOAD=1 with PC_DATA = mem[0x1FC] & ~3 and no WE3 for R15.
3. REGLIST=16'h0010, BASEREG=4, WBACK=1, MEM_VALID delayed 3 cycles → MEM_RE held 4 cycles, R4 ← loaded word, no BASEWB cycle.
4. REGLIST=0, WBACK=1, BASEREG=3, BASE=32'h40 → no MEM_RE, R3 ← 0x40, DONE 2 cycles after START.
5. BASE=32'hFFFF_FFFC, REGLIST=16'h0003, UP=1 → addresses 0xFFFFFFFC then 0x00000000, final base 0x4.
6. RST asserted while in REQ → outputs 0 in the same cycle, state IDLE, no WE3 afterwards; a subsequent START runs normally.
